// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the two-requester memory arbiter.
//            req_id_t  - requester index (0 = instruction fetch, 1 = data)
//            mem_req_t - one requester's memory request bundle
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Address bits actually decoded by the 1024-word firmware memory.
  localparam int MEM_ADDR_W = 10;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wr_mask;
    logic [31:0] wdata;
    logic        lock;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_lock.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_lock
// Purpose  : Lock tracker for mem_arbiter. Holds the grant for the lock owner
//            across read-modify-write sequences and forces a release after
//            LOCK_MAX consecutive locked cycles.
// Ports    : clk, reset_i      - clock, synchronous active-low reset
//            xfer             - a transfer is accepted this cycle
//            xfer_id          - requester that owns this cycle's transfer
//            xfer_lock        - lock request attached to the transfer
//            locked           - grant currently held for lock_owner
//            lock_owner       - requester holding (or last holding) the lock
//            timeout_now      - forced release happens at the end of this cycle
//            lock_timeout     - registered one-cycle pulse after forced release
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_lock
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic    clk,
  input  logic    reset_i,
  input  logic    xfer,
  input  req_id_t xfer_id,
  input  logic    xfer_lock,
  output logic    locked,
  output req_id_t lock_owner,
  output logic    timeout_now,
  output logic    lock_timeout
);

  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  logic [7:0] lock_cnt;
  // Set by a forced release: the previous owner may not re-lock until it has
  // completed an unlocked transfer, so the other requester gets through.
  logic       suppress;

  logic release_xfer;
  logic enter;
  logic owner_unlocked_xfer;

  assign release_xfer        = locked & xfer & ~xfer_lock;
  assign timeout_now         = locked & ~release_xfer & (lock_cnt == CNT_LAST);
  assign owner_unlocked_xfer = xfer & (xfer_id == lock_owner) & ~xfer_lock;
  assign enter               = ~locked & xfer & xfer_lock
                               & ~(suppress & (xfer_id == lock_owner));

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      locked       <= 1'b0;
      lock_owner   <= '0;
      lock_cnt     <= '0;
      suppress     <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      lock_timeout <= timeout_now;
      if (timeout_now) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
        suppress <= 1'b1;
      end else begin
        if (release_xfer) begin
          locked   <= 1'b0;
          lock_cnt <= '0;
        end else if (enter) begin
          locked     <= 1'b1;
          lock_owner <= xfer_id;
          lock_cnt   <= '0;
        end else if (locked) begin
          lock_cnt <= lock_cnt + 8'd1;
        end
        // A new lock by anyone, or an unlocked transfer by the old owner,
        // ends the post-timeout suppression.
        if (enter || owner_unlocked_xfer) begin
          suppress <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing a single-port 1024x32 memory between
//            the instruction fetch port (m0) and the load/store port (m1).
//            One transfer per clock, response one cycle after acceptance,
//            lock support with forced release after LOCK_MAX locked cycles.
// Ports    : clk, reset_i                - clock, synchronous active-low reset
//            mX_valid_i / mX_ready_o     - request handshake (X = 0,1)
//            mX_addr_i, mX_we_i, mX_wr_mask_i, mX_wdata_i, mX_lock_i
//                                        - request payload
//            mX_resp_o, mX_rdata_o       - registered response
//            mem_addr_o, mem_we_o, mem_wr_mask_o, mem_wdata_o, mem_rdata_i
//                                        - memory port (1-cycle read latency)
//            lock_timeout_o              - pulse after a forced lock release
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        m0_valid_i,
  output logic        m0_ready_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_wr_mask_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_lock_i,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_valid_i,
  output logic        m1_ready_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_wr_mask_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wr_mask_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        lock_timeout_o
);

  mem_req_t [1:0] req;
  logic     [1:0] valid;
  req_id_t        sel;
  mem_req_t       sel_req;
  logic           xfer;

  req_id_t        last_grant;
  logic [31:0]    last_addr;
  logic           resp_pending;
  req_id_t        resp_id;
  logic           resp_is_rd;
  logic           resp_live;

  logic           locked;
  req_id_t        lock_owner;
  logic           timeout_now;
  logic           lock_timeout_q;

  assign req[0]   = {m0_addr_i, m0_we_i, m0_wr_mask_i, m0_wdata_i, m0_lock_i};
  assign req[1]   = {m1_addr_i, m1_we_i, m1_wr_mask_i, m1_wdata_i, m1_lock_i};
  assign valid    = {m1_valid_i, m0_valid_i};

  // Grant selection. Holding reset low blocks every transfer so that all
  // outputs sit at their reset values for the whole reset cycle.
  always_comb begin
    sel = '0;
    if (locked) begin
      sel = lock_owner;
    end else if (&valid) begin
      sel = ~last_grant;
    end else if (valid[1]) begin
      sel = 1'b1;
    end
    sel_req = req[sel];
    xfer    = reset_i & valid[sel];
  end

  assign m0_ready_o    = xfer & (sel == 1'b0);
  assign m1_ready_o    = xfer & (sel == 1'b1);

  assign mem_we_o      = xfer & sel_req.we;
  assign mem_wr_mask_o = xfer ? sel_req.wr_mask : 4'h0;
  assign mem_wdata_o   = xfer ? sel_req.wdata   : 32'h0;
  assign mem_addr_o    = !reset_i ? 32'h0 : (xfer ? sel_req.addr : last_addr);

  // A pending response from the cycle before reset is discarded.
  assign resp_live     = reset_i & resp_pending;
  assign m0_resp_o     = resp_live & (resp_id == 1'b0);
  assign m1_resp_o     = resp_live & (resp_id == 1'b1);
  assign m0_rdata_o    = (m0_resp_o & resp_is_rd) ? mem_rdata_i : 32'h0;
  assign m1_rdata_o    = (m1_resp_o & resp_is_rd) ? mem_rdata_i : 32'h0;

  assign lock_timeout_o = reset_i & lock_timeout_q;

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      last_grant   <= 1'b1;
      last_addr    <= '0;
      resp_pending <= 1'b0;
      resp_id      <= '0;
      resp_is_rd   <= 1'b0;
    end else begin
      resp_pending <= xfer;
      if (xfer) begin
        resp_id    <= sel;
        resp_is_rd <= ~sel_req.we;
        last_grant <= sel;
        last_addr  <= sel_req.addr;
      end else if (timeout_now) begin
        // Forced release: mark the owner as most recent so the waiting
        // requester wins the next contention.
        last_grant <= lock_owner;
      end
    end
  end

  mem_arb_lock #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock (
    .clk          (clk),
    .reset_i      (reset_i),
    .xfer         (xfer),
    .xfer_id      (sel),
    .xfer_lock    (sel_req.lock),
    .locked       (locked),
    .lock_owner   (lock_owner),
    .timeout_now  (timeout_now),
    .lock_timeout (lock_timeout_q)
  );

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port 1024×32 firmware memory between the CPU instruction fetch port (m0) and the data/load-store port (m1). Round-robin grant every cycle, back-to-back accesses with one transfer per clock, registered per-requester response one cycle after acceptance. A lock input holds the memory for read-modify-write sequences, with a timeout that guarantees forward progress. Sits between the CPU bus ports and the memory block; the memory ports connect directly.

## Interface
- `LOCK_MAX`, default 16: maximum consecutive locked cycles before forced release (1..255).
- `clk` in 1: system clock.
- `reset_i` in 1: synchronous, active-low reset.
- `mX_valid_i` in 1 (X = 0,1): request valid.
- `mX_ready_o` out 1: request accepted this cycle (`valid & ready` = transfer).
- `mX_addr_i` in 32: word address; only [9:0] is used by memory.
- `mX_we_i` in 1: write enable.
- `mX_wr_mask_i` in 4: byte write mask, bit n = byte lane n.
- `mX_wdata_i` in 32: write data.
- `mX_lock_i` in 1: keep grant after this transfer.
- `mX_resp_o` out 1: one-cycle pulse, response for the transfer accepted last cycle (read or write).
- `mX_rdata_o` out 32: read data, valid when `mX_resp_o`=1 and the transfer was a read.
- `mem_addr_o` out 32, `mem_we_o` out 1, `mem_wr_mask_o` out 4, `mem_wdata_o` out 32: memory port.
- `mem_rdata_i` in 32: memory read data, registered in memory, 1-cycle latency.
- `lock_timeout_o` out 1: one-cycle pulse on forced lock release.

## Operation
- State: `last_grant` (1 b), `locked` (1 b), `lock_owner` (1 b), `lock_cnt` (8 b), `resp_pending` (1 b), `resp_id` (1 b), `resp_is_rd` (1 b).
- Arbitration is combinational each cycle.
  - Unlocked, one valid: that requester is selected.
  - Unlocked, both valid: the requester not equal to `last_grant` is selected.
  - Locked: only `lock_owner` may be selected; the other requester's `ready`=0.
- `mX_ready_o` = selected & `mX_valid_i`. At most one ready per cycle.
- Memory drive on a transfer: `mem_addr_o`/`mem_wr_mask_o`/`mem_wdata_o` from the selected requester; `mem_we_o` = `we_i` of the transfer.
- No transfer: `mem_we_o`=0, `mem_wr_mask_o`=0, `mem_addr_o` holds the last selected address, `mem_wdata_o` = 0.
- On a transfer: `last_grant` ← selected id.
- Lock entry and release:
  - Transfer with `lock_i`=1: `locked`←1, `lock_owner`←id.
  - Transfer by the owner with `lock_i`=0: `locked`←0.
  - Owner idle (`valid`=0) while locked: grant is still held.
- Lock counter: `lock_cnt` increments each locked cycle and clears on entry and on release.
- Timeout: when `lock_cnt` reaches `LOCK_MAX`-1 while locked and no releasing transfer occurs:
  - `locked`←0 and `last_grant`←owner, so the other requester wins the next contention.
  - `lock_timeout_o` pulses the following cycle.
  - The owner's `lock_i` is ignored until it completes a transfer with `lock_i`=0, or for 1 cycle minimum.
- Response: `resp_pending`, `resp_id` and `resp_is_rd` are registered from the transfer. Next cycle:
  - `m[resp_id]_resp_o`=1.
  - `m[resp_id]_rdata_o` = `mem_rdata_i` for reads, 0 for writes.
  - The non-addressed `rdata_o` is 0.
- Read-after-write to the same address in consecutive cycles returns the new data. A same-cycle read/write cannot occur because there is one transfer per cycle.

## Timing
- Reset values:
  - all `ready`/`resp`=0, `rdata`=0, `lock_timeout_o`=0;
  - `mem_we_o`=0, `mem_wr_mask_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0;
  - `last_grant`=1, so m0 wins the first contention; `locked`=0, `lock_cnt`=0, `resp_pending`=0.
- Latency: acceptance in cycle N → `resp_o` in cycle N+1. Throughput is 1 transfer/cycle, and the response of N overlaps the acceptance of N+1.
- Ready depends combinationally on valid. Requesters must not make valid depend on ready.
- Reset asserted in the cycle after a transfer: no `resp_o` is produced. In-flight state is discarded, and memory contents are unaffected except for a write already clocked.

## Structure
- Package `mem_arb_pkg`:
  - `typedef logic [0:0] req_id_t`;
  - `typedef struct packed {addr, we, wr_mask, wdata, lock} mem_req_t`;
  - constant `MEM_ADDR_W = 10`.
- Sub-module `mem_arb_lock`: owns `locked`, `lock_owner`, `lock_cnt` and the timeout pulse. The top level holds the grant mux and response registers.

## Test plan
- Reset, then both valid every cycle reading 0x004 (m0) and 0x008 (m1) → grants alternate m0, m1, m0…. Each `resp` arrives 1 cycle later with the correct `mX_rdata_o`, and the other port's `resp`=0.
- m1 writes 0xDEADBEEF, mask 4'b0101, to addr 0x010 over prior 0x11223344, then reads it the next cycle → `m1_resp_o` on both; read returns 0x11AD33EF.
- m1 locks: read 0x020 with `lock_i`=1, then write 0x020 with `lock_i`=0, while m0 is continuously valid → `m0_ready_o`=0 for both cycles; m0 is granted the cycle after the unlocked write.
- `LOCK_MAX`=4, m0 locks then idles with m1 valid → `m1_ready_o`=0 for 4 cycles, `lock_timeout_o` pulses once, then m1 is granted.
- Only m0 valid for 5 cycles → 5 consecutive m0 grants with no bubbles, and `mem_we_o` tracks `m0_we_i`.
- Reset pulled low in the cycle after an m0 read acceptance → `m0_resp_o` stays 0, and all outputs take their reset values.
